axis_pcap_arbiter: RTL

- Packet-granular round-robin arbiter that merges NUM_PORTS AXI4-Stream sources (e.g. MAC RX, MAC TX, loopback taps) into one stream feeding a single pcap_dumper instance.
- A grant is held from the first beat of a packet until its tlast handshake, so packets are never interleaved in the capture file.
- Provides per-port enable masking, a global capture enable, a source ID sideband and per-port packet counters.

---
 rtl/pcap_pkg.sv | 41 ++++
 rtl/rr_pick.sv | 41 ++++
 rtl/axis_pcap_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/pcap_pkg.sv
// Shared types and helpers for the pcap capture path arbiters and sequencers.
// Pure declarations: no timing and no flow control of its own.
package pcap_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   localparam int MAX_PORTS = 16;
   localparam int MAX_IDX_W = 4;

   // Width of a port index; never below one bit so single-port builds still elaborate.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   typedef struct packed {
      logic                 found;
      logic [MAX_IDX_W-1:0] idx;
   } rr_res_t;

   // Scan last+1, last+2, ... modulo n and return the first requesting index.
   function automatic rr_res_t rr_next(input logic [MAX_PORTS-1:0] req,
                                       input logic [MAX_IDX_W-1:0] last,
                                       input int n);
      rr_res_t r;
      int      c;
      r = '0;
      c = 0;
      for (int i = 1; i <= n; i++) begin
         c = (int'(last) + i) % n;
         if (!r.found && (((req >> c) & 16'd1) != 16'd0)) begin
            r.found = 1'b1;
            r.idx   = MAX_IDX_W'(c);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: rotate requests past the last winner, priority-encode, unrotate.
// Zero latency; no flow control, the caller decides when to register the result.
module rr_pick
   import pcap_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = idx_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [IW-1:0] grant,
   output logic          found
);

   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;
   int             start;
   int             off;
   int             g;

   always_comb begin
      start = int'(last) + 1;
      if (start >= N) start = 0;
      dbl   = {req, req} >> start;
      rot   = dbl[N-1:0];

      found = 1'b0;
      off   = 0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) begin
            found = 1'b1;
            off   = i;
         end
      end

      g = start + off;
      if (g >= N) g = g - N;
      grant = IW'(g);
   end

endmodule

// File: rtl/axis_pcap_arbiter.sv
// Packet-granular round-robin merge of NUM_PORTS AXI4-Stream sources into one pcap_dumper feed.
// One bubble cycle per grant then zero-latency beats; m_tready stalls only the granted source.
module axis_pcap_arbiter
   import pcap_pkg::*;
#(
   parameter int NUM_PORTS  = 4,
   parameter int AXIS_WIDTH = 64,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_PORTS*AXIS_WIDTH-1:0]   s_tdata,
   input  logic [NUM_PORTS*AXIS_WIDTH/8-1:0] s_tstrb,
   input  logic [NUM_PORTS-1:0]              s_tvalid,
   input  logic [NUM_PORTS-1:0]              s_tlast,
   output logic [NUM_PORTS-1:0]              s_tready,
   output logic [AXIS_WIDTH-1:0]             m_tdata,
   output logic [AXIS_WIDTH/8-1:0]           m_tstrb,
   output logic                              m_tvalid,
   output logic                              m_tlast,
   input  logic                              m_tready,
   output logic [$clog2(NUM_PORTS)-1:0]      m_tid,
   input  logic                              cap_en,
   input  logic [NUM_PORTS-1:0]              port_en,
   output logic [NUM_PORTS*CNT_WIDTH-1:0]    pkt_cnt,
   output logic                              busy
);

   localparam int IW = idx_w(NUM_PORTS);
   localparam int SW = AXIS_WIDTH / 8;

   arb_state_t     state;
   logic [IW-1:0]  grant;
   logic [IW-1:0]  last_grant;
   logic [IW-1:0]  pick;
   logic           pick_vld;
   logic [NUM_PORTS-1:0] req;
   logic           pkt_done;

   assign req = s_tvalid & port_en & {NUM_PORTS{cap_en}};

   rr_pick #(
      .N  (NUM_PORTS),
      .IW (IW)
   ) u_rr_pick (
      .req   (req),
      .last  (last_grant),
      .grant (pick),
      .found (pick_vld)
   );

   // Enables only gate new grants; once BUSY the packet always runs to its tlast.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         grant      <= '0;
         last_grant <= IW'(NUM_PORTS - 1);
      end else begin
         case (state)
            IDLE: begin
               if (pick_vld) begin
                  grant <= pick;
                  state <= BUSY;
               end
            end
            BUSY: begin
               if (pkt_done) begin
                  last_grant <= grant;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      m_tdata  = '0;
      m_tstrb  = '0;
      m_tvalid = 1'b0;
      m_tlast  = 1'b0;
      s_tready = '0;
      if (state == BUSY) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant == IW'(p)) begin
               m_tdata     = s_tdata[p*AXIS_WIDTH +: AXIS_WIDTH];
               m_tstrb     = s_tstrb[p*SW +: SW];
               m_tvalid    = s_tvalid[p];
               m_tlast     = s_tlast[p];
               s_tready[p] = m_tready;
            end
         end
      end
   end

   assign pkt_done = (state == BUSY) & m_tvalid & m_tready & m_tlast;
   assign busy     = (state == BUSY);
   assign m_tid    = (state == BUSY) ? grant : '0;

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_cnt
      logic [CNT_WIDTH-1:0] cnt;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            cnt <= '0;
         end else if (pkt_done && grant == IW'(p)) begin
            cnt <= cnt + CNT_WIDTH'(1);
         end
      end

      assign pkt_cnt[p*CNT_WIDTH +: CNT_WIDTH] = cnt;
   end

endmodule
